// File: rtl/round_key_sequencer.sv
// rtl/round_key_sequencer.sv - stores a round-key bundle and replays it one key per handshake per block
module round_key_sequencer #(
  parameter int NUM_ROUNDS = 16,
  parameter int RK_W       = 48
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush_i,
  input  logic                       keys_valid_i,
  input  logic [NUM_ROUNDS*RK_W-1:0] round_keys_i,
  output logic                       keys_ready_o,
  input  logic                       blk_valid_i,
  output logic                       blk_ready_o,
  output logic [RK_W-1:0]            rk_o,
  output logic                       rk_valid_o,
  input  logic                       rk_ready_i,
  output logic [3:0]                 rk_round_o,
  output logic                       rk_last_o,
  output logic                       key_loaded_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {EMPTY, LOADED, RUN} state_t;

  // The round index is carried on a 4-bit port, so the block supports up to 16 rounds.
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_t                       state, state_nxt;
  logic [3:0]                   idx, idx_nxt;
  logic [NUM_ROUNDS*RK_W-1:0]   bundle;
  logic                         load_en;
  logic                         done_nxt;
  logic [RK_W-1:0]              keys [NUM_ROUNDS];

  // Round 1 sits in the most significant slice of the bundle.
  for (genvar r = 0; r < NUM_ROUNDS; r++) begin : g_key
    assign keys[r] = bundle[(NUM_ROUNDS-1-r)*RK_W +: RK_W];
  end

  // State, index, bundle and done pulse; reset beats flush, flush beats all handshakes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= EMPTY;
      idx    <= '0;
      bundle <= '0;
      done_o <= 1'b0;
    end else if (flush_i) begin
      state  <= EMPTY;
      idx    <= '0;
      bundle <= '0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      done_o <= done_nxt;
      if (load_en) begin
        bundle <= round_keys_i;
      end
    end
  end

  // Next-state decode and handshake outputs; a key load wins over a block start.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    done_nxt     = 1'b0;
    load_en      = 1'b0;
    keys_ready_o = (state != RUN);
    blk_ready_o  = (state == LOADED) && !keys_valid_i;
    key_loaded_o = (state == LOADED) || (state == RUN);
    rk_valid_o   = 1'b0;
    rk_o         = '0;
    rk_round_o   = '0;
    rk_last_o    = 1'b0;
    case (state)
      EMPTY: begin
        if (keys_valid_i) begin
          load_en   = 1'b1;
          state_nxt = LOADED;
        end
      end
      LOADED: begin
        if (keys_valid_i) begin
          load_en   = 1'b1;
        end else if (blk_valid_i) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        rk_valid_o = 1'b1;
        rk_o       = keys[idx];
        rk_round_o = idx;
        rk_last_o  = (idx == LAST_IDX);
        if (rk_ready_i) begin
          if (idx == LAST_IDX) begin
            state_nxt = LOADED;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = idx + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// tb/tb_round_key_sequencer.sv - randomized and directed check of round_key_sequencer against a block-level model
module tb_round_key_sequencer;

  localparam int N = 16;
  localparam int W = 48;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           flush_i = 1'b0;
  logic           keys_valid_i = 1'b0;
  logic [N*W-1:0] round_keys_i = '0;
  logic           keys_ready_o;
  logic           blk_valid_i = 1'b0;
  logic           blk_ready_o;
  logic [W-1:0]   rk_o;
  logic           rk_valid_o;
  logic           rk_ready_i = 1'b0;
  logic [3:0]     rk_round_o;
  logic           rk_last_o;
  logic           key_loaded_o;
  logic           done_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: the bundle as a list of keys, plus whether one is held, whether a block is
  // being replayed, how many keys of it have been consumed, and the pending done pulse.
  logic [W-1:0] cur_keys [N];
  logic [W-1:0] m_keys   [N];
  bit           m_has, m_busy, m_done;
  int           m_pos;

  round_key_sequencer #(.NUM_ROUNDS(N), .RK_W(W)) dut (
    .clk(clk), .rstn(rstn), .flush_i(flush_i),
    .keys_valid_i(keys_valid_i), .round_keys_i(round_keys_i), .keys_ready_o(keys_ready_o),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .rk_o(rk_o), .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i),
    .rk_round_o(rk_round_o), .rk_last_o(rk_last_o),
    .key_loaded_o(key_loaded_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus layout: first round key in the top slice.
  task automatic drive_keys();
    for (int r = 0; r < N; r++) round_keys_i[(N-1-r)*W +: W] = cur_keys[r];
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model update at each rising edge.
  always @(posedge clk) begin
    if (!rstn || flush_i) begin
      m_has = 0; m_busy = 0; m_pos = 0; m_done = 0;
      for (int r = 0; r < N; r++) m_keys[r] = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (rk_ready_i) begin
          m_pos++;
          if (m_pos == N) begin
            m_busy = 0; m_pos = 0; m_done = 1;
          end
        end
      end else if (keys_valid_i) begin
        for (int r = 0; r < N; r++) m_keys[r] = cur_keys[r];
        m_has = 1;
      end else if (m_has && blk_valid_i) begin
        m_busy = 1; m_pos = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      chk("keys_ready", keys_ready_o, !m_busy);
      chk("blk_ready", blk_ready_o, m_has && !m_busy && !keys_valid_i);
      chk("rk_valid", rk_valid_o, m_busy);
      chk("rk", rk_o, m_busy ? m_keys[m_pos] : '0);
      chk("rk_round", rk_round_o, m_busy ? m_pos : 0);
      chk("rk_last", rk_last_o, m_busy && (m_pos == N-1));
      chk("key_loaded", key_loaded_o, m_has);
      chk("done", done_o, m_done);
    end
  end

  initial begin
    int guard;
    // Reset
    rstn = 0;
    tick(); tick();
    rstn = 1;
    cmp_en = 1;
    #2;
    chk("rst_keys_ready", keys_ready_o, 1);
    chk("rst_key_loaded", key_loaded_o, 0);
    chk("rst_rk_valid", rk_valid_o, 0);
    chk("rst_done", done_o, 0);

    // Load bundle with key r = 0x11 * r (r = 1..16)
    tick();
    for (int r = 0; r < N; r++) cur_keys[r] = 48'h11 * (r + 1);
    drive_keys();
    keys_valid_i = 1;
    tick();
    keys_valid_i = 0;
    #2;
    chk("load_key_loaded", key_loaded_o, 1);
    chk("load_blk_ready", blk_ready_o, 1);

    // Block with rk_ready held high
    tick();
    blk_valid_i = 1; rk_ready_i = 1;
    for (int r = 0; r < N; r++) begin
      tick();
      blk_valid_i = 0;
      #2;
      chk("seq_round", rk_round_o, r);
      chk("seq_key", rk_o, 48'h11 * (r + 1));
      chk("seq_last", rk_last_o, (r == N-1));
    end
    tick();
    #2;
    chk("seq_done", done_o, 1);
    chk("seq_idle", rk_valid_o, 0);

    // Block with random stalls
    tick();
    blk_valid_i = 1;
    tick();
    blk_valid_i = 0;
    guard = 0;
    while (!m_done && guard < 400) begin
      rk_ready_i = $urandom_range(0, 1);
      tick();
      guard++;
    end
    chk("stall_block_done_in_time", guard < 400, 1);
    rk_ready_i = 0;

    // Key load and block start together: load wins
    tick();
    for (int r = 0; r < N; r++) cur_keys[r] = 48'hB00 + r;
    drive_keys();
    keys_valid_i = 1; blk_valid_i = 1;
    #2;
    chk("both_blk_ready", blk_ready_o, 0);
    tick();
    keys_valid_i = 0; blk_valid_i = 0;
    #2;
    chk("both_no_start", rk_valid_o, 0);
    tick();
    blk_valid_i = 1; rk_ready_i = 1;
    tick();
    blk_valid_i = 0;
    #2;
    chk("both_new_key0", rk_o, 48'hB00);

    // Flush at round 7
    for (int r = 1; r <= 7; r++) tick();
    #2;
    chk("flush_at_round", rk_round_o, 7);
    flush_i = 1;
    tick();
    flush_i = 0;
    #2;
    chk("flush_rk_valid", rk_valid_o, 0);
    chk("flush_key_loaded", key_loaded_o, 0);
    chk("flush_done", done_o, 0);
    tick();
    #2;
    chk("flush_done_later", done_o, 0);

    // Reset mid-run
    for (int r = 0; r < N; r++) cur_keys[r] = {$urandom, $urandom};
    drive_keys();
    keys_valid_i = 1;
    tick();
    keys_valid_i = 0; blk_valid_i = 1;
    tick();
    blk_valid_i = 0;
    tick(); tick();
    rstn = 0;
    tick();
    rstn = 1; blk_valid_i = 1;
    #2;
    chk("rstrun_keys_ready", keys_ready_o, 1);
    chk("rstrun_rk", rk_o, 0);
    chk("rstrun_key_loaded", key_loaded_o, 0);
    chk("rstrun_blk_ready", blk_ready_o, 0);
    tick();
    blk_valid_i = 0;
    #2;
    chk("rstrun_no_start", rk_valid_o, 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      rstn         = ($urandom_range(0, 499) != 0);
      flush_i      = ($urandom_range(0, 99) == 0);
      keys_valid_i = ($urandom_range(0, 9) == 0);
      blk_valid_i  = ($urandom_range(0, 2) == 0);
      rk_ready_i   = $urandom_range(0, 1);
      if (keys_valid_i) begin
        for (int r = 0; r < N; r++) cur_keys[r] = {$urandom, $urandom};
        drive_keys();
      end
    end
    tick();
    rstn = 1; flush_i = 0; keys_valid_i = 0; blk_valid_i = 0; rk_ready_i = 0;
    tick();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 16, meaning the number of round keys per bundle and per block.
REQ-002 SHALL have parameter RK_W, default 48, meaning the width of one round key.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discards the stored bundle and aborts any block in progress.
REQ-006 SHALL have port keys_valid_i  input  1  a round-key bundle is offered.
REQ-007 SHALL have port round_keys_i  input  NUM_ROUNDS*RK_W (768)  bundle; round 1 key in [767:720], round 16 key in [47:0].
REQ-008 SHALL have port keys_ready_o  output  1  bundle can be accepted.
REQ-009 SHALL have port blk_valid_i  input  1  datapath requests a key sequence for one block.
REQ-010 SHALL have port blk_ready_o  output  1  block request can be accepted.
REQ-011 SHALL have port rk_o  output  RK_W  current round key.
REQ-012 SHALL have port rk_valid_o  output  1  rk_o is valid.
REQ-013 SHALL have port rk_ready_i  input  1  datapath consumes rk_o this cycle.
REQ-014 SHALL have port rk_round_o  output  4  zero-based index of the current round.
REQ-015 SHALL have port rk_last_o  output  1  current key is the final round key.
REQ-016 SHALL have port key_loaded_o  output  1  a valid bundle is stored.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse after the final key is consumed.

Function
REQ-018 SHALL implement the FSM states EMPTY, LOADED and RUN.
REQ-019 SHALL accept a bundle on keys_valid_i && keys_ready_o, storing round_keys_i and entering LOADED on the next edge, from either EMPTY or LOADED.
REQ-020 SHALL drive keys_ready_o = 1 in EMPTY and LOADED, and 0 in RUN.
REQ-021 SHALL drive blk_ready_o = (state == LOADED) && !keys_valid_i, so that a key load has priority over a block start in the same cycle.
REQ-022 SHALL, on blk_valid_i && blk_ready_o, enter RUN with round counter 0; rk_valid_o SHALL rise on the next cycle (one-cycle latency).
REQ-023 SHALL, in RUN, drive rk_o = stored bits [767-RK_W*idx -: RK_W], rk_round_o = idx, rk_valid_o = 1, and rk_last_o = (idx == NUM_ROUNDS-1).
REQ-024 SHALL increment idx on rk_valid_o && rk_ready_i, and hold rk_o, idx and rk_valid_o stable while rk_ready_i = 0.
REQ-025 SHALL, on the handshake with idx == NUM_ROUNDS-1, return to LOADED, reset idx to 0 and pulse done_o for exactly the next cycle.
REQ-026 SHALL guarantee at least one idle cycle between the final handshake of one block and the first key of the next block.
REQ-027 SHALL drive rk_o = 0, rk_round_o = 0, rk_valid_o = 0 and rk_last_o = 0 outside RUN.
REQ-028 SHALL retain the stored bundle across blocks until it is replaced or flushed.
REQ-029 SHALL, on flush_i = 1 in any state, go to EMPTY on the next edge, zero the stored bundle and idx, suppress done_o, and ignore keys_valid_i and blk_valid_i in that cycle.
REQ-030 SHALL drive key_loaded_o = 1 exactly when the state is LOADED or RUN.
REQ-031 SHALL keep blk_ready_o = 0 in EMPTY, so that blk_valid_i is ignored with no state change.

Reset
REQ-032 SHALL, when rstn = 0 at a clock edge, set state = EMPTY, idx = 0, the stored bundle = 0, and all outputs = 0 except keys_ready_o = 1 on the following cycle.
REQ-033 SHALL give rstn priority over flush_i and all handshakes, including when reset is asserted mid-RUN.

Verification
REQ-034 SHALL cover this scenario: load a bundle with key k = 48'h0000_0000_00k0 + k -> key_loaded_o = 1 one cycle later, with blk_ready_o = 1.
REQ-035 SHALL cover this scenario: blk_valid_i pulse with rk_ready_i = 1 held -> 16 consecutive keys with rk_round_o 0..15, rk_last_o only at 15, and done_o one cycle after round 15.
REQ-036 SHALL cover this scenario: rk_ready_i toggled randomly during RUN -> no key is skipped or repeated, and outputs are stable while stalled.
REQ-037 SHALL cover this scenario: keys_valid_i and blk_valid_i both asserted in LOADED -> new bundle stored, block not started, and the next block uses the new keys.
REQ-038 SHALL cover this scenario: flush_i at idx = 7 -> EMPTY next cycle, rk_valid_o = 0, no done_o, and key_loaded_o = 0.
REQ-039 SHALL cover this scenario: rstn = 0 mid-RUN -> all outputs 0 and keys_ready_o = 1 after the edge, and the bundle must be reloaded before a block is accepted.
